// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive path.
// Holds the framing-mode encodings, the legal parameter ranges and the
// capture-state encoding used by the deserialiser.
package i2s_pkg;

    // Framing modes: where the MSB sits relative to the lrck edge
    localparam int unsigned MODE_I2S = 0;  // MSB one bclk after the lrck edge
    localparam int unsigned MODE_LJ  = 1;  // MSB on the lrck-edge bclk

    // Legal parameter ranges
    localparam int unsigned DATA_W_MIN     = 8;
    localparam int unsigned DATA_W_MAX     = 32;
    localparam int unsigned FIFO_DEPTH_MIN = 2;
    localparam int unsigned FIFO_DEPTH_MAX = 64;

    // Deserialiser state: idle until the first slot start, shifting while
    // the word is incomplete, full once DATA_W bits are in (extra bits ignored)
    typedef enum logic [1:0] {
        CAP_IDLE  = 2'd0,
        CAP_SHIFT = 2'd1,
        CAP_FULL  = 2'd2
    } cap_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head output.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en, wr_data    write request; accepted when not full, or when full
//                     and a read is accepted in the same cycle
//   rd_en             pop the head when not empty
//   rd_data           registered head entry (valid while empty = 0)
//   full, empty       registered occupancy flags
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    // Pointer difference when full: only the wrap bit differs
    localparam logic [PTR_W-1:0] FULL_DIFF = PTR_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             wr_acc;
    logic             rd_acc;

    // Pointer update and next head selection
    always_comb begin
        rd_acc    = rd_en && !empty_q;
        wr_acc    = wr_en && (!full_q || rd_acc);
        wr_ptr_d  = wr_ptr_q + PTR_W'(wr_acc);
        rd_ptr_d  = rd_ptr_q + PTR_W'(rd_acc);
        full_d    = (wr_ptr_d - rd_ptr_d) == FULL_DIFF;
        empty_d   = (wr_ptr_d == rd_ptr_d);
        rd_data_d = rd_data_q;
        if (!empty_d) begin
            // The new head may be the entry being written right now
            if (wr_acc && (rd_ptr_d == wr_ptr_q)) begin
                rd_data_d = wr_data;
            end else begin
                rd_data_d = mem_q[rd_ptr_d[ADDR_W-1:0]];
            end
        end
    end

    // Storage array (no reset needed, guarded by the pointers)
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
        end
    end

    assign rd_data = rd_data_q;
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/i2s_rx_framer.sv
// I2S / left-justified serial receiver that pairs left and right words
// into stereo frames and buffers them in a FIFO.
// Ports:
//   bclk, rst         bit clock, synchronous active-high reset
//   lrck, sdata       word select (0 = left) and serial data, MSB first
//   clr_ovf           pulse clearing the sticky overflow flag
//   out_ready         downstream accepts the head frame
//   out_valid         head frame present on out_l / out_r
//   out_l, out_r      left / right samples of the head frame
//   ovf               sticky: a complete frame was dropped on a full FIFO
//   err_short         pulse: a slot ended before DATA_W bits were captured
module i2s_rx_framer
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MODE       = MODE_I2S,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              bclk,
    input  logic              rst,
    input  logic              lrck,
    input  logic              sdata,
    input  logic              clr_ovf,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_l,
    output logic [DATA_W-1:0] out_r,
    output logic              ovf,
    output logic              err_short
);

    localparam int unsigned CNT_W   = $clog2(DATA_W + 1);
    localparam int unsigned FRAME_W = 2 * DATA_W;

    logic              lrck_d_q, lrck_d_d;
    logic              lrck_d2_q, lrck_d2_d;
    cap_state_e        cap_state_q, cap_state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              chan_q, chan_d;
    logic [DATA_W-1:0] pend_l_q, pend_l_d;
    logic              pend_v_q, pend_v_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic              push_q, push_d;
    logic              ovf_q, ovf_d;
    logic              err_short_q, err_short_d;

    logic              slot_start;
    logic              slot_chan;
    logic              word_done;
    logic              word_chan;
    logic [DATA_W-1:0] word_val;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              drop;
    logic [FRAME_W-1:0] fifo_rd_data;

    // Slot boundary detection; I2S looks one bclk later than left-justified
    always_comb begin
        lrck_d_d  = lrck;
        lrck_d2_d = lrck_d_q;
        if (MODE == MODE_LJ) begin
            slot_start = (lrck != lrck_d_q);
            slot_chan  = lrck;
        end else begin
            slot_start = (lrck_d_q != lrck_d2_q);
            slot_chan  = lrck_d_q;
        end
    end

    // Deserialiser: a word completes after DATA_W bits, or early (left-aligned)
    // when the next slot start cuts it short
    always_comb begin
        cap_state_d = cap_state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        chan_d      = chan_q;
        word_done   = 1'b0;
        word_chan   = chan_q;
        word_val    = '0;
        err_short_d = 1'b0;
        if (slot_start) begin
            if (cap_state_q == CAP_SHIFT) begin
                word_done   = 1'b1;
                word_val    = shreg_q << (CNT_W'(DATA_W) - cnt_q);
                err_short_d = 1'b1;
            end
            cap_state_d = CAP_SHIFT;
            cnt_d       = CNT_W'(1);
            shreg_d     = {{(DATA_W-1){1'b0}}, sdata};
            chan_d      = slot_chan;
        end else if (cap_state_q == CAP_SHIFT) begin
            shreg_d = {shreg_q[DATA_W-2:0], sdata};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                cap_state_d = CAP_FULL;
                word_done   = 1'b1;
                word_val    = {shreg_q[DATA_W-2:0], sdata};
            end
        end
    end

    // Left/right pairing; an orphan right word is discarded
    always_comb begin
        pend_l_d = pend_l_q;
        pend_v_d = pend_v_q;
        frame_d  = frame_q;
        push_d   = 1'b0;
        if (word_done) begin
            if (!word_chan) begin
                pend_l_d = word_val;
                pend_v_d = 1'b1;
            end else if (pend_v_q) begin
                frame_d  = {pend_l_q, word_val};
                push_d   = 1'b1;
                pend_v_d = 1'b0;
            end
        end
    end

    // Overflow tracking; a new drop wins over a clear in the same cycle
    always_comb begin
        pop  = out_ready && !fifo_empty;
        drop = push_q && fifo_full && !pop;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge bclk) begin
        if (rst) begin
            lrck_d_q    <= 1'b0;
            lrck_d2_q   <= 1'b0;
            cap_state_q <= CAP_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            chan_q      <= 1'b0;
            pend_l_q    <= '0;
            pend_v_q    <= 1'b0;
            frame_q     <= '0;
            push_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_short_q <= 1'b0;
        end else begin
            lrck_d_q    <= lrck_d_d;
            lrck_d2_q   <= lrck_d2_d;
            cap_state_q <= cap_state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            chan_q      <= chan_d;
            pend_l_q    <= pend_l_d;
            pend_v_q    <= pend_v_d;
            frame_q     <= frame_d;
            push_q      <= push_d;
            ovf_q       <= ovf_d;
            err_short_q <= err_short_d;
        end
    end

    sync_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (bclk),
        .rst     (rst),
        .wr_en   (push_q),
        .wr_data (frame_q),
        .rd_en   (out_ready),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_l     = fifo_rd_data[FRAME_W-1:DATA_W];
    assign out_r     = fifo_rd_data[DATA_W-1:0];
    assign ovf       = ovf_q;
    assign err_short = err_short_q;

endmodule

// File: tb/tb_i2s_rx_framer.sv
// Scoreboard bench: instance A (16-bit, I2S, depth 4) and instance B
// (24-bit, left-justified). Stimulus pushes expected frames; monitors pop
// and compare whenever a frame is accepted downstream.
module tb_i2s_rx_framer;

    logic bclk = 1'b0;
    always #5 bclk = ~bclk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Instance A: DATA_W=16, MODE=0, FIFO_DEPTH=4
    logic        rst_a = 1'b1, lrck_a = 1'b0, sdata_a = 1'b0;
    logic        clr_a = 1'b0, rdy_a = 1'b0;
    logic        out_valid_a, ovf_a, err_a;
    logic [15:0] out_l_a, out_r_a;
    logic        dly_a = 1'b0;

    // Instance B: DATA_W=24, MODE=1
    logic        rst_b = 1'b1, lrck_b = 1'b0, sdata_b = 1'b0;
    logic        clr_b = 1'b0, rdy_b = 1'b0;
    logic        out_valid_b, ovf_b, err_b;
    logic [23:0] out_l_b, out_r_b;

    logic [31:0] q_a [$];
    logic [47:0] q_b [$];
    int          err_cnt_a = 0;
    int          err_cnt_b = 0;
    logic [31:0] hold_a    = '0;
    logic        hold_v_a  = 1'b0;
    logic [31:0] exp_a;
    logic [47:0] exp_b;
    int          e0;

    i2s_rx_framer #(.DATA_W(16), .MODE(0), .FIFO_DEPTH(4)) dut_a (
        .bclk(bclk), .rst(rst_a), .lrck(lrck_a), .sdata(sdata_a),
        .clr_ovf(clr_a), .out_ready(rdy_a), .out_valid(out_valid_a),
        .out_l(out_l_a), .out_r(out_r_a), .ovf(ovf_a), .err_short(err_a)
    );

    i2s_rx_framer #(.DATA_W(24), .MODE(1), .FIFO_DEPTH(4)) dut_b (
        .bclk(bclk), .rst(rst_b), .lrck(lrck_b), .sdata(sdata_b),
        .clr_ovf(clr_b), .out_ready(rdy_b), .out_valid(out_valid_b),
        .out_l(out_l_b), .out_r(out_r_b), .ovf(ovf_b), .err_short(err_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor A: frame scoreboard, hold stability, err_short counting
    always @(negedge bclk) begin
        #2;
        if (err_a === 1'b1) err_cnt_a++;
        if (out_valid_a && !rdy_a && hold_v_a)
            check("hold_a", 64'({out_l_a, out_r_a}), 64'(hold_a));
        hold_v_a = out_valid_a && !rdy_a;
        hold_a   = {out_l_a, out_r_a};
        if (out_valid_a && rdy_a) begin
            if (q_a.size() == 0) begin
                check("unexpected_a", 64'({out_l_a, out_r_a}), 64'hDEAD_0000_0000_0000);
            end else begin
                exp_a = q_a.pop_front();
                check("frame_a", 64'({out_l_a, out_r_a}), 64'(exp_a));
            end
        end
    end

    // Monitor B
    always @(negedge bclk) begin
        #2;
        if (err_b === 1'b1) err_cnt_b++;
        if (out_valid_b && rdy_b) begin
            if (q_b.size() == 0) begin
                check("unexpected_b", 64'({out_l_b, out_r_b}), 64'hDEAD_0000_0000_0000);
            end else begin
                exp_b = q_b.pop_front();
                check("frame_b", 64'({out_l_b, out_r_b}), 64'(exp_b));
            end
        end
    end

    // I2S drive: sdata lags lrck by one bclk
    task automatic drv_a(input logic lr, input logic b);
        @(negedge bclk);
        lrck_a  = lr;
        sdata_a = dly_a;
        dly_a   = b;
    endtask

    task automatic slot_a(input logic lr, input int n, input logic [31:0] w);
        for (int i = n - 1; i >= 0; i--) drv_a(lr, w[i]);
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) drv_a(lrck_a, 1'b0);
    endtask

    task automatic drain_a(input string name);
        for (int i = 0; i < 200 && q_a.size() != 0; i++) idle_a(1);
        check(name, 64'(q_a.size()), 64'd0);
    endtask

    // Left-justified drive: sdata aligned with lrck
    task automatic slot_b(input logic lr, input int n, input logic [31:0] w);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge bclk);
            lrck_b  = lr;
            sdata_b = w[i];
        end
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge bclk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge bclk);
        check("rst_valid_a", 64'(out_valid_a), 64'd0);
        check("rst_l_a",     64'(out_l_a),     64'd0);
        check("rst_r_a",     64'(out_r_a),     64'd0);
        check("rst_ovf_a",   64'(ovf_a),       64'd0);
        check("rst_err_a",   64'(err_a),       64'd0);
        check("rst_valid_b", 64'(out_valid_b), 64'd0);
        check("rst_lr_b",    64'({out_l_b, out_r_b}), 64'd0);

        // B: 24-bit LJ in 32-bit slots, trailing 0xFF ignored
        rdy_b = 1'b1;
        slot_b(1'b1, 32, 32'h0);
        q_b.push_back({24'h800001, 24'h7FFFFE});
        slot_b(1'b0, 32, {24'h800001, 8'hFF});
        slot_b(1'b1, 32, {24'h7FFFFE, 8'hFF});
        for (int i = 0; i < 100 && q_b.size() != 0; i++) @(negedge bclk);
        check("drain_b", 64'(q_b.size()), 64'd0);
        check("err_b", 64'(err_cnt_b), 64'd0);

        // A: basic I2S frame
        rdy_a = 1'b1;
        slot_a(1'b1, 16, 32'h0);
        q_a.push_back({16'hA5C3, 16'h1234});
        slot_a(1'b0, 16, 32'hA5C3);
        slot_a(1'b1, 16, 32'h1234);
        idle_a(1);
        drain_a("drain_basic");
        check("err_basic", 64'(err_cnt_a), 64'd0);

        // A: short 8-bit slots left-aligned, then a full pair
        e0 = err_cnt_a;
        q_a.push_back({16'hAB00, 16'hCD00});
        q_a.push_back({16'h1111, 16'h2222});
        slot_a(1'b0, 8, 32'hAB);
        slot_a(1'b1, 8, 32'hCD);
        slot_a(1'b0, 16, 32'h1111);
        slot_a(1'b1, 16, 32'h2222);
        idle_a(1);
        drain_a("drain_short");
        check("err_short_cnt", 64'(err_cnt_a - e0), 64'd2);

        // A: five frames into a depth-4 FIFO with no pops
        rdy_a = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) q_a.push_back({16'h1100 + 16'(i), 16'h2200 + 16'(i)});
            slot_a(1'b0, 16, 32'(16'h1100 + 16'(i)));
            slot_a(1'b1, 16, 32'(16'h2200 + 16'(i)));
        end
        idle_a(4);
        check("ovf_set", 64'(ovf_a), 64'd1);
        check("held_cnt", 64'(q_a.size()), 64'd4);
        rdy_a = 1'b1;
        drain_a("drain_ovf");
        check("ovf_sticky", 64'(ovf_a), 64'd1);
        idle_a(1);
        clr_a = 1'b1;
        idle_a(1);
        clr_a = 1'b0;
        idle_a(1);
        check("ovf_clr", 64'(ovf_a), 64'd0);

        // A: full FIFO, pop coincides with push of the fifth frame
        rdy_a = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            q_a.push_back({16'h3300 + 16'(i), 16'h4400 + 16'(i)});
            slot_a(1'b0, 16, 32'(16'h3300 + 16'(i)));
            slot_a(1'b1, 16, 32'(16'h4400 + 16'(i)));
        end
        idle_a(1);
        idle_a(1);
        rdy_a = 1'b1;
        idle_a(1);
        rdy_a = 1'b0;
        idle_a(3);
        check("ovf_pp", 64'(ovf_a), 64'd0);
        check("count_pp", 64'(q_a.size()), 64'd4);
        rdy_a = 1'b1;
        drain_a("drain_pp");
        idle_a(2);
        check("empty_pp", 64'(out_valid_a), 64'd0);

        // A: reset at bit 7 of a left slot
        e0 = err_cnt_a;
        for (int j = 0; j < 16; j++) begin
            drv_a(1'b0, 1'b1);
            rst_a = (j == 7);
        end
        rst_a = 1'b0;
        slot_a(1'b1, 16, 32'hBEEF);
        q_a.push_back({16'h5A5A, 16'hC3C3});
        slot_a(1'b0, 16, 32'h5A5A);
        slot_a(1'b1, 16, 32'hC3C3);
        idle_a(1);
        drain_a("drain_rst");
        idle_a(8);
        check("err_rst", 64'(err_cnt_a - e0), 64'd0);
        check("ovf_rst", 64'(ovf_a), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_rx_framer.md
I2S_RX_FRAMER -- requirements
Module: i2s_rx_framer

Interface
REQ-001 Parameter DATA_W, default 16, received sample width in bits (8..32).
REQ-002 Parameter MODE, default 0, 0 = I2S (MSB one bclk after lrck edge), 1 = left-justified (MSB on the lrck-edge bclk).
REQ-003 Parameter FIFO_DEPTH, default 4, stereo frames buffered (power of two, 2..64).
REQ-004 bclk  input  1  bit clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 lrck  input  1  word select, 0 = left slot, 1 = right slot.
REQ-007 sdata  input  1  serial data, MSB first.
REQ-008 clr_ovf  input  1  one-cycle pulse, clears ovf.
REQ-009 out_ready  input  1  downstream accepts frame.
REQ-010 out_valid  output  1  frame available at out_l/out_r.
REQ-011 out_l  output  DATA_W  left sample of head frame.
REQ-012 out_r  output  DATA_W  right sample of head frame.
REQ-013 ovf  output  1  sticky: a complete frame was dropped because the FIFO was full.
REQ-014 err_short  output  1  one-cycle pulse: a slot ended before DATA_W bits were captured.

Function
REQ-015 lrck SHALL be registered twice (lrck_d, lrck_d2); an edge is lrck != lrck_d.
REQ-016 Slot start SHALL be the cycle where lrck != lrck_d (MODE=1) or lrck_d != lrck_d2 (MODE=0); sdata on that cycle is the MSB.
REQ-017 Slot channel SHALL be the lrck level at slot start (MODE=1: lrck; MODE=0: lrck_d).
REQ-018 Capture SHALL shift in exactly DATA_W bits MSB first, including the start-cycle bit; bits beyond DATA_W in the slot are ignored.
REQ-019 If the next slot start arrives with fewer than DATA_W bits captured, the partial word SHALL be left-aligned with zero LSBs, stored as complete, and err_short pulsed on that start cycle.
REQ-020 A left word SHALL be held pending; the right word completing after it SHALL form a frame {left,right}; a right word without a pending left word SHALL be discarded.
REQ-021 A second left word before a right word SHALL replace the pending left word.
REQ-022 The frame SHALL be pushed into the FIFO on the cycle after its last bit is captured (push latency 1).
REQ-023 out_valid SHALL assert the cycle after a push into an empty FIFO; out_l/out_r SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 A pop occurs when out_valid and out_ready are both 1; next head is presented the following cycle.
REQ-025 Push when full SHALL be accepted if a pop occurs the same cycle; otherwise the frame is dropped and ovf set.
REQ-026 Push and pop on an empty FIFO SHALL not bypass; the frame appears next cycle.
REQ-027 ovf SHALL clear on clr_ovf; if clr_ovf coincides with a new drop, ovf stays 1.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an extra bit distinguishing full from empty.

Reset
REQ-029 On rst: out_valid=0, out_l=0, out_r=0, ovf=0, err_short=0, FIFO empty, lrck_d=lrck_d2=0, pending left cleared, bit counter idle.
REQ-030 After rst deasserts, no capture SHALL occur until the first slot start; the partial slot in progress at reset is ignored.
REQ-031 rst mid-slot SHALL discard all partial and pending data; no frame pushed.

Structure
REQ-032 Mode encodings (MODE_I2S=0, MODE_LJ=1) and width limits SHALL live in shared package i2s_pkg.
REQ-033 FIFO SHALL be a sub-module sync_fifo (parameters WIDTH=2*DATA_W, DEPTH), registered output, full/empty flags.
REQ-034 Deserialiser and frame pairing SHALL remain in i2s_rx_framer.

Verification
REQ-035 DATA_W=16, MODE=0, 16-bit slots, L=0xA5C3, R=0x1234, out_ready=1 -> one frame out_l=0xA5C3, out_r=0x1234, err_short never.
REQ-036 DATA_W=24, MODE=1, 32-bit slots, L=0x800001, R=0x7FFFFE, trailing 8 bits 0xFF -> out_l=0x800001, out_r=0x7FFFFE.
REQ-037 DATA_W=16, 8-bit slots, L bits 0xAB, R bits 0xCD -> out_l=0xAB00, out_r=0xCD00, err_short pulsed twice.
REQ-038 FIFO_DEPTH=4, out_ready=0, 5 frames -> 4 frames held, ovf=1; out_ready=1 -> frames 1..4 in order; clr_ovf -> ovf=0.
REQ-039 rst asserted for 1 cycle at bit 7 of a left slot -> no frame from that slot; next full L/R pair delivered correctly.
REQ-040 FIFO full, pop and push same cycle -> no drop, ovf=0, count stays 4.
